ru_wr_arbiter: RTL and testbench

- Shares the single register-file write port (rd / DataWr / RUWr) between two writeback requesters.
- Port A is the ALU/immediate writeback and has default priority. Port B is the load/multicycle-unit writeback.
- Valid/ready handshake on both sides; a starvation counter guarantees B forward progress.
- Output stage is registered and drives the register file's write port directly.

---
 rtl/ru_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_ru_wr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ru_wr_arbiter.sv
// Two-requester arbiter for the register-file write port: A has priority, B is force-granted after starvation.
// Optional macro RU_ARB_FWD_EN adds a bypass view of the uncommitted output-stage write.
module ru_wr_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic [4:0]  rd,
    output logic [31:0] DataWr,
    output logic        RUWr,
    output logic        grant_b,
    output logic        starve_evt
`ifdef RU_ARB_FWD_EN
    ,
    input  logic [4:0]  fwd_rs1,
    input  logic [4:0]  fwd_rs2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2
`endif
);

    // Handshake: a port transfers on the rising CLK edge where valid && ready;
    // a requester holds rd/data stable while valid && !ready. Readiness depends
    // only on arbitration because the register file never stalls.

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;
    logic             we_q, we_d;
    logic             gb_q, gb_d;
    logic             se_q, se_d;

    logic force_b;
    logic a_xfer;
    logic b_xfer;

    assign force_b = b_valid && (cnt_q == LIMIT);

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (force_b) begin
            b_ready = 1'b1;
        end else if (a_valid) begin
            a_ready = 1'b1;
        end else begin
            b_ready = b_valid;
        end
    end

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    // Counter only runs while B is waiting; any B transfer or withdrawal restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (!b_valid || b_xfer) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        gb_d   = gb_q;
        we_d   = 1'b0;
        if (b_xfer) begin
            rd_d   = b_rd;
            data_d = b_data;
            gb_d   = 1'b1;
            we_d   = (b_rd != 5'd0);
        end else if (a_xfer) begin
            rd_d   = a_rd;
            data_d = a_data;
            gb_d   = 1'b0;
            we_d   = (a_rd != 5'd0);
        end
        se_d = force_b;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q  <= '0;
            rd_q   <= 5'd0;
            data_q <= 32'd0;
            we_q   <= 1'b0;
            gb_q   <= 1'b0;
            se_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            we_q   <= we_d;
            gb_q   <= gb_d;
            se_q   <= se_d;
        end
    end

    assign rd         = rd_q;
    assign DataWr     = data_q;
    assign RUWr       = we_q;
    assign grant_b    = gb_q;
    assign starve_evt = se_q;

`ifdef RU_ARB_FWD_EN
    assign fwd_hit1  = we_q && (rd_q == fwd_rs1) && (rd_q != 5'd0);
    assign fwd_hit2  = we_q && (rd_q == fwd_rs2) && (rd_q != 5'd0);
    assign fwd_data1 = data_q;
    assign fwd_data2 = data_q;
`endif

endmodule

// File: tb/tb_ru_wr_arbiter.sv
// Directed bench for ru_wr_arbiter: driver pushes hand-computed expectations, negedge monitor pops and compares.
module tb_ru_wr_arbiter;

  logic        CLK;
  logic        RSTn;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic [4:0]  rd;
  logic [31:0] DataWr;
  logic        RUWr;
  logic        grant_b;
  logic        starve_evt;
`ifdef RU_ARB_FWD_EN
  logic [4:0]  fwd_rs1;
  logic [4:0]  fwd_rs2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  ru_wr_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rd(rd), .DataWr(DataWr), .RUWr(RUWr), .grant_b(grant_b), .starve_evt(starve_evt)
`ifdef RU_ARB_FWD_EN
    , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  // Entry layout: {a_ready, b_ready, rd[4:0], DataWr[31:0], RUWr, grant_b, starve_evt}
  localparam int W = 42;
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int vec_idx  = 0;

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check_now(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // driver: apply one cycle of inputs plus expected readies (this cycle) and output stage (this cycle)
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                     input logic e_ar, input logic e_br,
                     input logic [4:0] e_rd, input logic [31:0] e_data,
                     input logic e_we, input logic e_gb, input logic e_se);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    exp_q.push_back({e_ar, e_br, e_rd, e_data, e_we, e_gb, e_se});
    @(posedge CLK);
    #2;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    forever begin
      @(negedge CLK);
      if (RSTn && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {a_ready, b_ready, rd, DataWr, RUWr, grant_b, starve_evt};
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL vec%0d: got ar=%b br=%b rd=%0d data=0x%08h we=%b gb=%b se=%b, required ar=%b br=%b rd=%0d data=0x%08h we=%b gb=%b se=%b",
                   vec_idx, got_v[41], got_v[40], got_v[39:35], got_v[34:3], got_v[2], got_v[1], got_v[0],
                   exp_v[41], exp_v[40], exp_v[39:35], exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
        end else begin
          n_pass++;
        end
`ifdef RU_ARB_FWD_EN
        check_now("fwd_hit1", {63'd0, fwd_hit1}, {63'd0, exp_v[2] && (exp_v[39:35] == 5'd6)});
        check_now("fwd_data1", {32'd0, fwd_data1}, {32'd0, exp_v[34:3]});
        check_now("fwd_hit2", {63'd0, fwd_hit2}, 64'd0);
`endif
        vec_idx++;
      end
    end
  end

  // stimulus
  initial begin
`ifdef RU_ARB_FWD_EN
    fwd_rs1 = 5'd6;
    fwd_rs2 = 5'd0;
`endif
    RSTn = 1'b0;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h55;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    #1;
    check_now("reset_out", {22'd0, rd, DataWr, RUWr, grant_b, starve_evt}, 64'd0);
    check_now("reset_ready", {62'd0, a_ready, b_ready}, 64'd2);
    repeat (2) @(posedge CLK);
    #2;
    check_now("reset_hold", {22'd0, rd, DataWr, RUWr, grant_b, starve_evt}, 64'd0);
    RSTn = 1'b1;

    //    A v rd  data          B v rd data          ar br  rd   data          we gb se
    cyc(1, 5'd5, 32'h55,       0, 5'd0, 32'h0,      1, 0, 5'd0, 32'h0,        0, 0, 0);
    cyc(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0,      1, 0, 5'd5, 32'h55,       1, 0, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd3, 32'hDEADBEEF, 1, 0, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd3, 32'hDEADBEEF, 0, 0, 0);
    // contention: B starves 4 cycles, then is forced
    cyc(1, 5'd10, 32'hA0,      1, 5'd7, 32'h11,     1, 0, 5'd3, 32'hDEADBEEF, 0, 0, 0);
    cyc(1, 5'd11, 32'hA1,      1, 5'd7, 32'h11,     1, 0, 5'd10, 32'hA0,      1, 0, 0);
    cyc(1, 5'd12, 32'hA2,      1, 5'd7, 32'h11,     1, 0, 5'd11, 32'hA1,      1, 0, 0);
    cyc(1, 5'd13, 32'hA3,      1, 5'd7, 32'h11,     1, 0, 5'd12, 32'hA2,      1, 0, 0);
    cyc(1, 5'd14, 32'hA4,      1, 5'd7, 32'h11,     0, 1, 5'd13, 32'hA3,      1, 0, 0);
    cyc(1, 5'd14, 32'hA4,      0, 5'd0, 32'h0,      1, 0, 5'd7, 32'h11,       1, 1, 1);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd14, 32'hA4,      1, 0, 0);
    // x0 write from B
    cyc(0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 0, 1, 5'd14, 32'hA4,    0, 0, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd0, 32'hFFFFFFFF, 0, 1, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd0, 32'hFFFFFFFF, 0, 1, 0);
    // back-to-back alternation
    cyc(1, 5'd1, 32'h101,      0, 5'd0, 32'h0,      1, 0, 5'd0, 32'hFFFFFFFF, 0, 1, 0);
    cyc(0, 5'd0, 32'h0,        1, 5'd9, 32'h909,    0, 1, 5'd1, 32'h101,      1, 0, 0);
    cyc(1, 5'd2, 32'h202,      0, 5'd0, 32'h0,      1, 0, 5'd9, 32'h909,      1, 1, 0);
    cyc(0, 5'd0, 32'h0,        1, 5'd9, 32'h919,    0, 1, 5'd2, 32'h202,      1, 0, 0);
    cyc(1, 5'd3, 32'h303,      0, 5'd0, 32'h0,      1, 0, 5'd9, 32'h919,      1, 1, 0);
    cyc(0, 5'd0, 32'h0,        1, 5'd9, 32'h929,    0, 1, 5'd3, 32'h303,      1, 0, 0);
    cyc(1, 5'd4, 32'h404,      0, 5'd0, 32'h0,      1, 0, 5'd9, 32'h929,      1, 1, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd4, 32'h404,      1, 0, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd4, 32'h404,      0, 0, 0);
    // B transfer after partial wait must restart the starvation count
    cyc(1, 5'd5, 32'h505,      1, 5'd8, 32'h808,    1, 0, 5'd4, 32'h404,      0, 0, 0);
    cyc(1, 5'd6, 32'h1234,     1, 5'd8, 32'h808,    1, 0, 5'd5, 32'h505,      1, 0, 0);
    cyc(0, 5'd0, 32'h0,        1, 5'd8, 32'h808,    0, 1, 5'd6, 32'h1234,     1, 0, 0);
    cyc(1, 5'd7, 32'h707,      1, 5'd8, 32'h818,    1, 0, 5'd8, 32'h808,      1, 1, 0);
    cyc(1, 5'd7, 32'h717,      1, 5'd8, 32'h818,    1, 0, 5'd7, 32'h707,      1, 0, 0);
    cyc(1, 5'd7, 32'h727,      1, 5'd8, 32'h818,    1, 0, 5'd7, 32'h717,      1, 0, 0);
    cyc(1, 5'd7, 32'h737,      1, 5'd8, 32'h818,    1, 0, 5'd7, 32'h727,      1, 0, 0);
    cyc(1, 5'd7, 32'h747,      1, 5'd8, 32'h818,    0, 1, 5'd7, 32'h737,      1, 0, 0);
    cyc(1, 5'd7, 32'h747,      0, 5'd0, 32'h0,      1, 0, 5'd8, 32'h818,      1, 1, 1);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd7, 32'h747,      1, 0, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd7, 32'h747,      0, 0, 0);
    // B withdrawing must also restart the starvation count
    cyc(1, 5'd1, 32'h1,        1, 5'd2, 32'h2,      1, 0, 5'd7, 32'h747,      0, 0, 0);
    cyc(1, 5'd1, 32'h11,       0, 5'd0, 32'h0,      1, 0, 5'd1, 32'h1,        1, 0, 0);
    cyc(1, 5'd1, 32'h21,       1, 5'd2, 32'h2,      1, 0, 5'd1, 32'h11,       1, 0, 0);
    cyc(1, 5'd1, 32'h31,       1, 5'd2, 32'h2,      1, 0, 5'd1, 32'h21,       1, 0, 0);
    cyc(1, 5'd1, 32'h41,       1, 5'd2, 32'h2,      1, 0, 5'd1, 32'h31,       1, 0, 0);
    cyc(1, 5'd1, 32'h51,       1, 5'd2, 32'h2,      1, 0, 5'd1, 32'h41,       1, 0, 0);
    cyc(1, 5'd1, 32'h61,       1, 5'd2, 32'h2,      0, 1, 5'd1, 32'h51,       1, 0, 0);
    cyc(1, 5'd1, 32'h61,       0, 5'd0, 32'h0,      1, 0, 5'd2, 32'h2,        1, 1, 1);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd1, 32'h61,       1, 0, 0);
    // reset while a write sits in the output stage
    cyc(1, 5'd4, 32'h99,       1, 5'd6, 32'h66,     1, 0, 5'd1, 32'h61,       0, 0, 0);
    check_now("pending_write", {22'd0, rd, DataWr, RUWr, grant_b, starve_evt},
              {22'd0, 5'd4, 32'h99, 1'b1, 1'b0, 1'b0});
    RSTn = 1'b0;
    #1;
    check_now("midreset_out", {22'd0, rd, DataWr, RUWr, grant_b, starve_evt}, 64'd0);
    check_now("midreset_ready", {62'd0, a_ready, b_ready}, 64'd2);
    @(posedge CLK);
    #2;
    RSTn = 1'b1;
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd0, 32'h0,        0, 0, 0);
    cyc(1, 5'd4, 32'h99,       1, 5'd6, 32'h66,     1, 0, 5'd0, 32'h0,        0, 0, 0);
    cyc(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      0, 0, 5'd4, 32'h99,       1, 0, 0);

    @(negedge CLK);
    #1;
    check_now("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
